// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption: one round per clock through a shared
// SubBytes/ShiftRows datapath, internal MixColumns and AddRoundKey.
//
// Handshake: start is accepted only on an edge where the FSM is IDLE (busy=0,
// done=0). There is no queue; start seen in ROUND or DONE is dropped. done is
// a single-cycle strobe that coincides with the first cycle ct_o holds the new
// ciphertext, and ct_o is held until the next completion or reset.
//
// Byte k of every 128-bit bus sits at [127-8k -: 8]; byte 4c+r is row r,
// column c (FIPS-197 input order).

// Combinational SubBytes followed by ShiftRows.
// The S-box is computed as the GF(2^8) inverse (x^254) followed by the affine map.
module sub_bytes_shft_rows (
  input  logic [127:0] sb_i,
  output logic [127:0] sb_o
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse via x^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x7   = gf_mul(x6, a);
    x14  = gf_mul(x7, x7);
    x15  = gf_mul(x14, a);
    x30  = gf_mul(x15, x15);
    x31  = gf_mul(x30, a);
    x62  = gf_mul(x31, x31);
    x63  = gf_mul(x62, a);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, a);
    return gf_mul(x127, x127);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Row r of the output takes column (c+r) mod 4 of the input, substituted.
  always_comb begin
    sb_o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sb_o[127-8*(4*c+r) -: 8] = sbox(sb_i[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
  end

endmodule

// Round sequencer: owns the cipher state, the round counter and the FSM.
module aes128_round_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] pt_i,
  output logic [3:0]   rk_idx_o,
  input  logic [127:0] rk_i,
  output logic         busy,
  output logic         done,
  output logic [127:0] ct_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } fsm_t;

  fsm_t         fsm_r;
  fsm_t         fsm_nx;
  logic [3:0]   round_r;
  logic [3:0]   round_nx;
  logic [127:0] state_r;
  logic [127:0] state_nx;
  logic [127:0] ct_nx;
  logic [127:0] sbsr;
  logic [127:0] mc;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; s0 is row 0 (most significant byte).
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    s0 = col[31:24];
    s1 = col[23:16];
    s2 = col[15:8];
    s3 = col[7:0];
    return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
            xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
  endfunction

  sub_bytes_shft_rows u_sbsr (
    .sb_i (state_r),
    .sb_o (sbsr)
  );

  // MixColumns over the four columns of the SubBytes/ShiftRows result.
  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mix_col(sbsr[127-32*c -: 32]);
    end
  end

  // Next-state, datapath selection and decoded outputs.
  always_comb begin
    fsm_nx   = fsm_r;
    round_nx = round_r;
    state_nx = state_r;
    ct_nx    = ct_o;
    busy     = 1'b0;
    done     = 1'b0;
    rk_idx_o = 4'd0;
    case (fsm_r)
      S_IDLE: begin
        if (start) begin
          state_nx = pt_i ^ rk_i;
          round_nx = 4'd1;
          fsm_nx   = S_ROUND;
        end
      end
      S_ROUND: begin
        busy     = 1'b1;
        rk_idx_o = round_r;
        if (round_r == 4'd10) begin
          // Final round skips MixColumns.
          ct_nx    = sbsr ^ rk_i;
          round_nx = 4'd0;
          fsm_nx   = S_DONE;
        end else begin
          state_nx = mc ^ rk_i;
          round_nx = round_r + 4'd1;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        fsm_nx = S_IDLE;
      end
      default: begin
        fsm_nx   = S_IDLE;
        round_nx = 4'd0;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r   <= S_IDLE;
      round_r <= 4'd0;
      state_r <= '0;
      ct_o    <= '0;
    end else begin
      fsm_r   <= fsm_nx;
      round_r <= round_nx;
      state_r <= state_nx;
      ct_o    <= ct_nx;
    end
  end

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Directed bench for aes128_round_ctrl using FIPS-197 vectors and a
// table-driven key-expansion model that answers rk_idx_o combinationally.
module tb_aes128_round_ctrl;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  localparam logic [7:0] RCON [10] = '{
    8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36
  };

  // ---------------- clock / reset / DUT ----------------
  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] pt_i;
  logic [3:0]   rk_idx_o;
  logic [127:0] rk_i;
  logic         busy;
  logic         done;
  logic [127:0] ct_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes128_round_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pt_i     (pt_i),
    .rk_idx_o (rk_idx_o),
    .rk_i     (rk_i),
    .busy     (busy),
    .done     (done),
    .ct_o     (ct_o)
  );

  // Key-schedule store model: round keys of the currently loaded key.
  logic [127:0] rk_tab [11];
  assign rk_i = (rk_idx_o <= 4'd10) ? rk_tab[rk_idx_o] : 128'h0;

  int checks;
  int failures;

  // Results captured by run_block.
  int           obs_lat;
  logic [127:0] obs_ct;
  logic [3:0]   seen_rk [12];

  // ---------------- driver tasks ----------------
  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^
            {RCON[i/4-1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Start one block and follow it to done (bounded); records latency in
  // cycles after the accepting edge, the ciphertext and the rk_idx_o trace.
  task automatic run_block(input logic [127:0] key, input logic [127:0] pt);
    load_key(key);
    obs_lat = -1;
    obs_ct  = '0;
    for (int i = 0; i < 12; i++) seen_rk[i] = 4'hf;
    @(negedge clk);
    seen_rk[0] = rk_idx_o;
    start = 1'b1;
    pt_i  = pt;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start = 1'b0;
      pt_i  = ~pt;
      if (n <= 11) seen_rk[n] = rk_idx_o;
      if (done) begin
        obs_lat = n;
        obs_ct  = ct_o;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (rk_idx_o !== 4'd0) begin failures++; $display("FAIL reset_rk_idx: got %0d expected 0", rk_idx_o); end
    checks++; if (ct_o !== 128'h0) begin failures++; $display("FAIL reset_ct: got %h expected 0", ct_o); end
    rst = 1'b0;
  endtask

  task automatic test_vector_b;
    run_block(KEY_B, PT_B);
    checks++; if (obs_lat != 11) begin failures++; $display("FAIL vec_b_latency: got %0d expected 11", obs_lat); end
    checks++; if (obs_ct !== CT_B) begin failures++; $display("FAIL vec_b_ct: got %h expected %h", obs_ct, CT_B); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL vec_b_done_width: got %b expected 0", done); end
    checks++; if (ct_o !== CT_B) begin failures++; $display("FAIL vec_b_ct_hold: got %h expected %h", ct_o, CT_B); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL vec_b_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_vector_c;
    logic [3:0] exp_rk;
    run_block(KEY_C, PT_C);
    checks++; if (obs_lat != 11) begin failures++; $display("FAIL vec_c_latency: got %0d expected 11", obs_lat); end
    checks++; if (obs_ct !== CT_C) begin failures++; $display("FAIL vec_c_ct: got %h expected %h", obs_ct, CT_C); end
    for (int i = 0; i < 12; i++) begin
      exp_rk = (i == 0 || i == 11) ? 4'd0 : 4'(i);
      checks++;
      if (seen_rk[i] !== exp_rk) begin
        failures++;
        $display("FAIL vec_c_rk_idx[%0d]: got %0d expected %0d", i, seen_rk[i], exp_rk);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int           accept_at [2];
    int           n_acc;
    int           n_done;
    int           done_at [2];
    logic         prev_busy;
    logic         prev_done;
    logic         wide_done;
    logic [127:0] ct1;
    logic [127:0] ct2;
    n_acc = 0; n_done = 0; wide_done = 1'b0;
    accept_at[0] = -1; accept_at[1] = -1; done_at[0] = -1; done_at[1] = -1;
    ct1 = '0; ct2 = '0;
    load_key(KEY_B);
    @(negedge clk);
    prev_busy = busy;
    prev_done = done;
    start = 1'b1;
    pt_i  = PT_B;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (busy && !prev_busy && n_acc < 2) begin accept_at[n_acc] = n; n_acc++; end
      if (done) begin
        if (prev_done) wide_done = 1'b1;
        if (n_done == 0) begin
          ct1 = ct_o;
          load_key(KEY_C);
          pt_i = PT_C;
        end else if (n_done == 1) begin
          ct2 = ct_o;
          start = 1'b0;
        end
        if (n_done < 2) done_at[n_done] = n;
        n_done++;
      end
      prev_busy = busy;
      prev_done = done;
    end
    start = 1'b0;
    checks++; if (n_acc != 2) begin failures++; $display("FAIL b2b_accept_count: got %0d expected 2", n_acc); end
    checks++; if (accept_at[1] - accept_at[0] != 12) begin failures++; $display("FAIL b2b_period: got %0d expected 12", accept_at[1] - accept_at[0]); end
    checks++; if (n_done != 2) begin failures++; $display("FAIL b2b_done_count: got %0d expected 2", n_done); end
    checks++; if (done_at[0] != 11) begin failures++; $display("FAIL b2b_first_done: got %0d expected 11", done_at[0]); end
    checks++; if (wide_done !== 1'b0) begin failures++; $display("FAIL b2b_done_width: got %b expected 0", wide_done); end
    checks++; if (ct1 !== CT_B) begin failures++; $display("FAIL b2b_ct_b: got %h expected %h", ct1, CT_B); end
    checks++; if (ct2 !== CT_C) begin failures++; $display("FAIL b2b_ct_c: got %h expected %h", ct2, CT_C); end
  endtask

  task automatic test_ignored_start;
    int   n_done;
    int   done_n;
    logic [3:0] rk_at5;
    n_done = 0; done_n = -1; rk_at5 = 4'hf;
    obs_ct = '0;
    load_key(KEY_C);
    @(negedge clk);
    start = 1'b1;
    pt_i  = PT_C;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 5) begin
        rk_at5 = rk_idx_o;
        start  = 1'b1;
        pt_i   = PT_B;
      end
      if (done) begin
        n_done++;
        done_n = n;
        obs_ct = ct_o;
        start  = 1'b1;
        pt_i   = PT_B;
      end
    end
    checks++; if (rk_at5 !== 4'd5) begin failures++; $display("FAIL ign_round5_idx: got %0d expected 5", rk_at5); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL ign_done_count: got %0d expected 1", n_done); end
    checks++; if (done_n != 11) begin failures++; $display("FAIL ign_done_cycle: got %0d expected 11", done_n); end
    checks++; if (obs_ct !== CT_C) begin failures++; $display("FAIL ign_ct: got %h expected %h", obs_ct, CT_C); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_busy_end: got %b expected 0", busy); end
    checks++; if (ct_o !== CT_C) begin failures++; $display("FAIL ign_ct_hold: got %h expected %h", ct_o, CT_C); end
  endtask

  task automatic test_reset_mid;
    int n_done;
    logic [3:0] rk_at7;
    n_done = 0; rk_at7 = 4'hf;
    load_key(KEY_B);
    @(negedge clk);
    start = 1'b1;
    pt_i  = PT_B;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) n_done++;
      if (n == 7) begin
        rk_at7 = rk_idx_o;
        rst    = 1'b1;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    checks++; if (rk_at7 !== 4'd7) begin failures++; $display("FAIL rstmid_round7_idx: got %0d expected 7", rk_at7); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (ct_o !== 128'h0) begin failures++; $display("FAIL rstmid_ct: got %h expected 0", ct_o); end
    checks++; if (rk_idx_o !== 4'd0) begin failures++; $display("FAIL rstmid_rk_idx: got %0d expected 0", rk_idx_o); end
    if (done) n_done++;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    checks++; if (n_done != 0) begin failures++; $display("FAIL rstmid_no_done: got %0d expected 0", n_done); end
    run_block(KEY_B, PT_B);
    checks++; if (obs_lat != 11) begin failures++; $display("FAIL rstmid_rerun_latency: got %0d expected 11", obs_lat); end
    checks++; if (obs_ct !== CT_B) begin failures++; $display("FAIL rstmid_rerun_ct: got %h expected %h", obs_ct, CT_B); end
    @(negedge clk);
  endtask

  task automatic test_collision;
    int n_busy;
    n_busy = 0;
    load_key(KEY_C);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    pt_i  = PT_C;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL coll_busy: got %b expected 0", busy); end
    checks++; if (rk_idx_o !== 4'd0) begin failures++; $display("FAIL coll_rk_idx: got %0d expected 0", rk_idx_o); end
    checks++; if (ct_o !== 128'h0) begin failures++; $display("FAIL coll_ct: got %h expected 0", ct_o); end
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (busy || done) n_busy++;
    end
    checks++; if (n_busy != 0) begin failures++; $display("FAIL coll_stays_idle: got %0d active cycles expected 0", n_busy); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    pt_i     = '0;
    load_key(KEY_B);
    test_reset();
    test_vector_b();
    test_vector_c();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    test_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
